// File: rtl/if2_fetch_if.sv
// rtl/if2_fetch_if.sv - IF1 to IF2 fetch packet interface (PC, exception, BTB metadata, backpressure)

interface if2_fetch_if;
  logic        if2_vld_i;
  logic [31:0] if2_sip_vpc_i;
  logic        if2_excp_vld_i;
  logic [3:0]  if2_excp_code_i;
  logic [1:0]  if2_btype_i;
  logic [1:0]  if2_bm_pred_i;
  logic [31:0] if2_btb_target_i;
  logic        if2_btb_index_i;
  logic        if2_btb_hit_i;
  logic        if2_btb_way_i;
  logic        if2_busy_o;

  // IF1 side: produces the packet, observes backpressure
  modport master (
    output if2_vld_i, if2_sip_vpc_i, if2_excp_vld_i, if2_excp_code_i,
    output if2_btype_i, if2_bm_pred_i, if2_btb_target_i, if2_btb_index_i,
    output if2_btb_hit_i, if2_btb_way_i,
    input  if2_busy_o
  );

  // IF2 side: consumes the packet, drives backpressure
  modport slave (
    input  if2_vld_i, if2_sip_vpc_i, if2_excp_vld_i, if2_excp_code_i,
    input  if2_btype_i, if2_bm_pred_i, if2_btb_target_i, if2_btb_index_i,
    input  if2_btb_hit_i, if2_btb_way_i,
    output if2_busy_o
  );
endinterface

// File: rtl/if2_fetch.sv
// rtl/if2_fetch.sv - second fetch stage: icache fetch, slot trim, decode handoff (option: IF2_FAST_ACCEPT_EN)

module if2_fetch #(
  parameter logic [3:0] EXCP_ACCESS_FAULT = 4'd1
) (
  input  logic        cpu_clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  if2_fetch_if.slave  if2,
  output logic        icache_req_o,
  output logic [28:0] icache_addr_o,
  input  logic        icache_ack_i,
  input  logic [63:0] icache_data_i,
  input  logic        icache_err_i,
  output logic        dec_vld_o,
  input  logic        dec_busy_i,
  output logic [31:0] dec_pc_o,
  output logic [31:0] dec_instr0_o,
  output logic [31:0] dec_instr1_o,
  output logic        dec_instr1_vld_o,
  output logic        dec_excp_vld_o,
  output logic [3:0]  dec_excp_code_o,
  output logic [1:0]  dec_btype_o,
  output logic [1:0]  dec_bm_pred_o,
  output logic [31:0] dec_btb_target_o,
  output logic        dec_btb_index_o,
  output logic        dec_btb_hit_o,
  output logic        dec_btb_way_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0] pc_q;
  logic        excp_vld_q;
  logic [3:0]  excp_code_q;
  logic [1:0]  btype_q;
  logic [1:0]  bm_pred_q;
  logic [31:0] btb_target_q;
  logic        btb_index_q;
  logic        btb_hit_q;
  logic        btb_way_q;
  logic [31:0] instr0_q;
  logic [31:0] instr1_q;
  logic        instr1_vld_q;

  logic        xfer;
  logic        accept_slot;
  logic        accept;
  logic        ack_take;
  logic        taken;
  logic [31:0] slot0;
  logic [31:0] slot1;
  logic        slot1_vld;

  assign xfer = (state_q == OUT) && !dec_busy_i;

`ifdef IF2_FAST_ACCEPT_EN
  // The transfer edge doubles as an accept edge, removing the IDLE bubble
  assign accept_slot = (state_q == IDLE) || xfer;
`else
  assign accept_slot = (state_q == IDLE);
`endif

  assign accept   = accept_slot && if2.if2_vld_i && !flush_i;
  assign ack_take = (state_q == REQ) && icache_ack_i && !flush_i;

  // State register
  always_ff @(posedge cpu_clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush wins, then a new packet, then cache ack / decode transfer
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = if2.if2_excp_vld_i ? OUT : REQ;
    end else begin
      case (state_q)
        REQ:     if (icache_ack_i) state_d = OUT;
        OUT:     if (xfer) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Trim the fetched block to the slots that belong to this packet
  always_comb begin
    taken     = btb_hit_q && ((btype_q != 2'b00) || bm_pred_q[1]);
    slot0     = icache_data_i[31:0];
    slot1     = icache_data_i[63:32];
    slot1_vld = !(taken && !btb_index_q);
    if (pc_q[2]) begin
      slot0     = icache_data_i[63:32];
      slot1     = 32'd0;
      slot1_vld = 1'b0;
    end
  end

  // Packet latch on accept and slot capture on cache ack
  always_ff @(posedge cpu_clk_i) begin
    if (reset_i) begin
      pc_q         <= 32'd0;
      excp_vld_q   <= 1'b0;
      excp_code_q  <= 4'd0;
      btype_q      <= 2'd0;
      bm_pred_q    <= 2'd0;
      btb_target_q <= 32'd0;
      btb_index_q  <= 1'b0;
      btb_hit_q    <= 1'b0;
      btb_way_q    <= 1'b0;
      instr0_q     <= 32'd0;
      instr1_q     <= 32'd0;
      instr1_vld_q <= 1'b0;
    end else if (accept) begin
      pc_q         <= if2.if2_sip_vpc_i;
      excp_vld_q   <= if2.if2_excp_vld_i;
      excp_code_q  <= if2.if2_excp_code_i;
      btype_q      <= if2.if2_btype_i;
      bm_pred_q    <= if2.if2_bm_pred_i;
      btb_target_q <= if2.if2_btb_target_i;
      btb_index_q  <= if2.if2_btb_index_i;
      btb_hit_q    <= if2.if2_btb_hit_i;
      btb_way_q    <= if2.if2_btb_way_i;
      instr0_q     <= 32'd0;
      instr1_q     <= 32'd0;
      instr1_vld_q <= 1'b0;
    end else if (ack_take) begin
      if (icache_err_i) begin
        excp_vld_q   <= 1'b1;
        excp_code_q  <= EXCP_ACCESS_FAULT;
        instr0_q     <= 32'd0;
        instr1_q     <= 32'd0;
        instr1_vld_q <= 1'b0;
      end else begin
        instr0_q     <= slot0;
        instr1_q     <= slot1;
        instr1_vld_q <= slot1_vld;
      end
    end
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    icache_req_o   = (state_q == REQ);
    icache_addr_o  = (state_q == REQ) ? pc_q[31:3] : 29'd0;
    dec_vld_o      = (state_q == OUT);
`ifdef IF2_FAST_ACCEPT_EN
    if2.if2_busy_o = (state_q == OUT) ? dec_busy_i : (state_q != IDLE);
`else
    if2.if2_busy_o = (state_q != IDLE);
`endif
  end

  assign dec_pc_o         = pc_q;
  assign dec_instr0_o     = instr0_q;
  assign dec_instr1_o     = instr1_q;
  assign dec_instr1_vld_o = instr1_vld_q;
  assign dec_excp_vld_o   = excp_vld_q;
  assign dec_excp_code_o  = excp_code_q;
  assign dec_btype_o      = btype_q;
  assign dec_bm_pred_o    = bm_pred_q;
  assign dec_btb_target_o = btb_target_q;
  assign dec_btb_index_o  = btb_index_q;
  assign dec_btb_hit_o    = btb_hit_q;
  assign dec_btb_way_o    = btb_way_q;

endmodule
